// File: rtl/hdc_sequencer.sv
// ----------------------------------------------------------------------------
// hdc_sequencer
//
// Per-message controller for the HDC spam/ham pipeline. It accepts one message
// descriptor, streams the message characters from the message buffer into the
// tokenizer/encoder, then starts the similarity classifier. The classification
// is returned through a valid/ready handshake.
//
// Optional feature macro: HDC_STATS_EN (adds saturating result counters).
//
// Ports:
//   i_clk, i_rst_n        clock (rising edge), asynchronous active-low reset
//   i_msg_valid/o_msg_ready, i_msg_length, i_msg_label
//                         message descriptor handshake (ready only while idle)
//   o_char_rd_en, o_char_addr, i_char_data
//                         message buffer read port (data one cycle after strobe)
//   o_enc_start, o_enc_char_valid, o_enc_char, o_enc_last, i_enc_done
//                         encoder control and character stream
//   o_cls_start, i_cls_done, i_cls_result
//                         classifier control
//   o_out_valid/i_out_ready, o_out_class, o_out_correct, o_out_err
//                         result handshake
//   o_stat_total, o_stat_correct (HDC_STATS_EN only)
//                         handshake count and correct, error-free count
// ----------------------------------------------------------------------------
module hdc_sequencer #(
    parameter int unsigned MAX_LEN = 160,
    parameter int unsigned CHAR_W  = 32,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_msg_valid,
    output logic              o_msg_ready,
    input  logic [15:0]       i_msg_length,
    input  logic              i_msg_label,
    output logic              o_char_rd_en,
    output logic [ADDR_W-1:0] o_char_addr,
    input  logic [CHAR_W-1:0] i_char_data,
    output logic              o_enc_start,
    output logic              o_enc_char_valid,
    output logic [CHAR_W-1:0] o_enc_char,
    output logic              o_enc_last,
    input  logic              i_enc_done,
    output logic              o_cls_start,
    input  logic              i_cls_done,
    input  logic              i_cls_result,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic              o_out_class,
    output logic              o_out_correct,
    output logic              o_out_err
`ifdef HDC_STATS_EN
    ,
    output logic [15:0]       o_stat_total,
    output logic [15:0]       o_stat_correct
`endif
);

    // One extra bit so that a length of exactly 2**ADDR_W is representable.
    localparam int unsigned LEN_W = ADDR_W + 1;
    localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StFeed,
        StWaitEnc,
        StCls,
        StWaitCls,
        StRespond
    } state_e;

    state_e              r_state;
    logic [LEN_W-1:0]    r_len;
    logic                r_label;
    logic                r_err_trunc;
    logic [CNT_W-1:0]    r_cnt;

    logic                r_msg_ready;
    logic                r_char_rd_en;
    logic [ADDR_W-1:0]   r_char_addr;
    logic                r_enc_start;
    logic                r_enc_char_valid;
    logic                r_enc_last;
    logic                r_cls_start;
    logic                r_out_valid;
    logic                r_out_class;
    logic                r_out_correct;
    logic                r_out_err;

    logic                w_trunc;
    logic [LEN_W-1:0]    w_len;
    logic                w_at_last;
    logic                w_cnt_expired;

    assign w_trunc       = (i_msg_length > 16'(MAX_LEN));
    assign w_len         = w_trunc ? LEN_W'(MAX_LEN) : i_msg_length[LEN_W-1:0];
    assign w_at_last     = ({1'b0, r_char_addr} == (r_len - LEN_W'(1)));
    assign w_cnt_expired = (r_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state          <= StIdle;
            r_len            <= '0;
            r_label          <= 1'b0;
            r_err_trunc      <= 1'b0;
            r_cnt            <= '0;
            r_msg_ready      <= 1'b1;
            r_char_rd_en     <= 1'b0;
            r_char_addr      <= '0;
            r_enc_start      <= 1'b0;
            r_enc_char_valid <= 1'b0;
            r_enc_last       <= 1'b0;
            r_cls_start      <= 1'b0;
            r_out_valid      <= 1'b0;
            r_out_class      <= 1'b0;
            r_out_correct    <= 1'b0;
            r_out_err        <= 1'b0;
        end else begin
            r_enc_start      <= 1'b0;
            r_cls_start      <= 1'b0;
            // Buffer data arrives one cycle after the read strobe, so the
            // stream qualifiers are the strobe delayed by one cycle.
            r_enc_char_valid <= r_char_rd_en;
            r_enc_last       <= r_char_rd_en & w_at_last;

            unique case (r_state)
                StIdle: begin
                    if (i_msg_valid && r_msg_ready) begin
                        r_msg_ready <= 1'b0;
                        r_label     <= i_msg_label;
                        r_len       <= w_len;
                        r_err_trunc <= w_trunc;
                        if (i_msg_length == 16'd0) begin
                            // Empty message: skip the datapath entirely.
                            r_state       <= StRespond;
                            r_out_valid   <= 1'b1;
                            r_out_class   <= 1'b0;
                            r_out_correct <= ~i_msg_label;
                            r_out_err     <= 1'b1;
                        end else begin
                            r_state     <= StStart;
                            r_enc_start <= 1'b1;
                        end
                    end
                end

                StStart: begin
                    r_state      <= StFeed;
                    r_char_rd_en <= 1'b1;
                    r_char_addr  <= '0;
                end

                StFeed: begin
                    if (r_char_rd_en) begin
                        if (w_at_last) begin
                            r_char_rd_en <= 1'b0;
                        end else begin
                            r_char_addr <= r_char_addr + ADDR_W'(1);
                        end
                    end
                    // Leave only after the final character has been presented.
                    if (r_enc_last) begin
                        r_state     <= StWaitEnc;
                        r_char_addr <= '0;
                        r_cnt       <= '0;
                    end
                end

                StWaitEnc: begin
                    if (i_enc_done) begin
                        r_state     <= StCls;
                        r_cls_start <= 1'b1;
                    end else if (w_cnt_expired) begin
                        r_state       <= StRespond;
                        r_out_valid   <= 1'b1;
                        r_out_class   <= 1'b0;
                        r_out_correct <= ~r_label;
                        r_out_err     <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                StCls: begin
                    r_state <= StWaitCls;
                    r_cnt   <= '0;
                end

                StWaitCls: begin
                    if (i_cls_done) begin
                        r_state       <= StRespond;
                        r_out_valid   <= 1'b1;
                        r_out_class   <= i_cls_result;
                        r_out_correct <= (i_cls_result == r_label);
                        r_out_err     <= r_err_trunc;
                    end else if (w_cnt_expired) begin
                        r_state       <= StRespond;
                        r_out_valid   <= 1'b1;
                        r_out_class   <= 1'b0;
                        r_out_correct <= ~r_label;
                        r_out_err     <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                StRespond: begin
                    if (i_out_ready) begin
                        r_state       <= StIdle;
                        r_out_valid   <= 1'b0;
                        r_out_class   <= 1'b0;
                        r_out_correct <= 1'b0;
                        r_out_err     <= 1'b0;
                        r_msg_ready   <= 1'b1;
                    end
                end

                default: begin
                    r_state     <= StIdle;
                    r_msg_ready <= 1'b1;
                end
            endcase
        end
    end

    assign o_msg_ready      = r_msg_ready;
    assign o_char_rd_en     = r_char_rd_en;
    assign o_char_addr      = r_char_addr;
    assign o_enc_start      = r_enc_start;
    assign o_enc_char_valid = r_enc_char_valid;
    // The buffer read data is already registered; forward it while qualified.
    assign o_enc_char       = r_enc_char_valid ? i_char_data : '0;
    assign o_enc_last       = r_enc_last;
    assign o_cls_start      = r_cls_start;
    assign o_out_valid      = r_out_valid;
    assign o_out_class      = r_out_class;
    assign o_out_correct    = r_out_correct;
    assign o_out_err        = r_out_err;

`ifdef HDC_STATS_EN
    logic [15:0] r_stat_total;
    logic [15:0] r_stat_correct;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stat_total   <= '0;
            r_stat_correct <= '0;
        end else if (r_out_valid && i_out_ready) begin
            if (r_stat_total != 16'hFFFF) begin
                r_stat_total <= r_stat_total + 16'd1;
            end
            if (r_out_correct && !r_out_err && (r_stat_correct != 16'hFFFF)) begin
                r_stat_correct <= r_stat_correct + 16'd1;
            end
        end
    end

    assign o_stat_total   = r_stat_total;
    assign o_stat_correct = r_stat_correct;
`endif

endmodule

// File: tb/tb_hdc_sequencer.sv
// Self-checking bench for hdc_sequencer with buffer, encoder and classifier
// responders and a message-level reference model.
module tb_hdc_sequencer;

    localparam int MAX_LEN = 160;
    localparam int CHAR_W  = 32;
    localparam int ADDR_W  = 8;
    localparam int TIMEOUT = 16;

    logic              clk;
    logic              rst_n;
    logic              msg_valid;
    logic              o_msg_ready;
    logic [15:0]       msg_length;
    logic              msg_label;
    logic              o_char_rd_en;
    logic [ADDR_W-1:0] o_char_addr;
    logic [CHAR_W-1:0] char_data;
    logic              o_enc_start;
    logic              o_enc_char_valid;
    logic [CHAR_W-1:0] o_enc_char;
    logic              o_enc_last;
    logic              enc_done;
    logic              o_cls_start;
    logic              cls_done;
    logic              cls_result;
    logic              o_out_valid;
    logic              out_ready;
    logic              o_out_class;
    logic              o_out_correct;
    logic              o_out_err;
`ifdef HDC_STATS_EN
    logic [15:0]       stat_total;
    logic [15:0]       stat_correct;
`endif

    wire [48:0] w_outs = {o_char_rd_en, o_char_addr, o_enc_start, o_enc_char_valid, o_enc_char,
                          o_enc_last, o_cls_start, o_out_valid, o_out_class, o_out_correct,
                          o_out_err};
    wire [2:0]  w_res  = {o_out_class, o_out_correct, o_out_err};

    hdc_sequencer #(
        .MAX_LEN(MAX_LEN),
        .CHAR_W (CHAR_W),
        .ADDR_W (ADDR_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_msg_valid     (msg_valid),
        .o_msg_ready     (o_msg_ready),
        .i_msg_length    (msg_length),
        .i_msg_label     (msg_label),
        .o_char_rd_en    (o_char_rd_en),
        .o_char_addr     (o_char_addr),
        .i_char_data     (char_data),
        .o_enc_start     (o_enc_start),
        .o_enc_char_valid(o_enc_char_valid),
        .o_enc_char      (o_enc_char),
        .o_enc_last      (o_enc_last),
        .i_enc_done      (enc_done),
        .o_cls_start     (o_cls_start),
        .i_cls_done      (cls_done),
        .i_cls_result    (cls_result),
        .o_out_valid     (o_out_valid),
        .i_out_ready     (out_ready),
        .o_out_class     (o_out_class),
        .o_out_correct   (o_out_correct),
        .o_out_err       (o_out_err)
`ifdef HDC_STATS_EN
        ,
        .o_stat_total    (stat_total),
        .o_stat_correct  (stat_correct)
`endif
    );

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;

    logic [CHAR_W-1:0] mem [256];

    // Responder controls.
    int enc_delay = 0;
    int cls_delay = 0;
    bit enc_hang = 0;
    bit cls_hang = 0;
    bit enc_noise = 0;
    bit cls_val = 0;

    // Observations of one message.
    int                q_addr[$];
    logic [CHAR_W-1:0] q_char[$];
    int                q_last[$];
    int n_enc_start, n_cls_start;
    int c_enc_start, c_first_rd, c_last, c_cls_start;

    int exp_total = 0;
    int exp_correct = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Synchronous message buffer: data for a strobe appears in the next cycle.
    initial begin : buf_model
        logic              p_en;
        logic [ADDR_W-1:0] p_addr;
        char_data = '0;
        forever begin
            @(negedge clk);
            p_en   = o_char_rd_en;
            p_addr = o_char_addr;
            @(posedge clk);
            #1;
            char_data = p_en ? mem[p_addr] : CHAR_W'($urandom);
        end
    end

    initial begin : enc_model
        int cnt;
        cnt = 0;
        enc_done = 1'b0;
        forever begin
            @(negedge clk);
            enc_done = 1'b0;
            if (!rst_n) begin
                cnt = 0;
            end else begin
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) enc_done = 1'b1;
                end
                if (o_enc_char_valid && o_enc_last && !enc_hang) cnt = enc_delay + 1;
                else if (o_enc_char_valid && enc_noise) enc_done = 1'b1;
            end
        end
    end

    initial begin : cls_model
        int cnt;
        cnt = 0;
        cls_done = 1'b0;
        cls_result = 1'b0;
        forever begin
            @(negedge clk);
            cls_done = 1'b0;
            cls_result = 1'($urandom);
            if (!rst_n) begin
                cnt = 0;
            end else begin
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        cls_done = 1'b1;
                        cls_result = cls_val;
                    end
                end
                if (o_cls_start && !cls_hang) cnt = cls_delay + 1;
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (o_enc_start) begin
                    n_enc_start++;
                    c_enc_start = cyc;
                end
                if (o_cls_start) begin
                    n_cls_start++;
                    c_cls_start = cyc;
                end
                if (o_char_rd_en) begin
                    if (q_addr.size() == 0) c_first_rd = cyc;
                    q_addr.push_back(int'(o_char_addr));
                end
                if (o_enc_char_valid) begin
                    q_char.push_back(o_enc_char);
                    if (o_enc_last) begin
                        q_last.push_back(q_char.size() - 1);
                        c_last = cyc;
                    end
                end
            end
        end
    end

    // Message-level reference: what the result must be for a descriptor.
    function automatic void ref_msg(input int len, input bit label, input bit cres,
                                    input bit hang, output int l, output logic [2:0] res);
        bit cls;
        bit err;
        l   = (len > MAX_LEN) ? MAX_LEN : len;
        cls = (len == 0 || hang) ? 1'b0 : cres;
        err = (len == 0) || (len > MAX_LEN) || hang;
        res = {cls, cls == label, err};
    endfunction

    task automatic clear_obs();
        q_addr.delete();
        q_char.delete();
        q_last.delete();
        n_enc_start = 0;
        n_cls_start = 0;
        c_enc_start = -1;
        c_first_rd  = -1;
        c_last      = -1;
        c_cls_start = -1;
    endtask

    // Drives one descriptor and waits (bounded) for the result.
    task automatic run_msg(input int len, input bit label, input bit cres,
                           output int t_acc, output int t_out, output bit got);
        int w;
        w = 0;
        while (o_msg_ready !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        clear_obs();
        msg_length = 16'(len);
        msg_label  = label;
        cls_val    = cres;
        msg_valid  = 1'b1;
        t_acc      = cyc;
        @(negedge clk);
        msg_valid  = 1'b0;
        msg_length = 16'($urandom);
        msg_label  = 1'($urandom);
        w = 0;
        while (o_out_valid !== 1'b1 && w < 600) begin
            @(negedge clk);
            w++;
        end
        got   = (o_out_valid === 1'b1);
        t_out = cyc;
    endtask

    task automatic handshake(input logic [2:0] res, output int t_hs);
        out_ready = 1'b1;
        t_hs = cyc;
        if (o_out_valid === 1'b1) begin
            exp_total++;
            if (res[1] && !res[0]) exp_correct++;
        end
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_total++;
        if (w_outs !== 49'd0) $display("FAIL reset_outs: got %h want 0", w_outs);
        else n_pass++;
        n_total++;
        if (o_msg_ready !== 1'b1) $display("FAIL reset_msg_ready: got %b want 1", o_msg_ready);
        else n_pass++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_total++;
        if (w_outs !== 49'd0 || o_msg_ready !== 1'b1)
            $display("FAIL idle_outs: got %h/%b want 0/1", w_outs, o_msg_ready);
        else n_pass++;
    endtask

    task automatic test_basic();
        int ta, to, th, l;
        bit got;
        logic [2:0] er;
        mem[0] = 32'h61;
        mem[1] = 32'h62;
        mem[2] = 32'h63;
        enc_delay = 2;
        cls_delay = 1;
        ref_msg(3, 1'b1, 1'b1, 1'b0, l, er);
        run_msg(3, 1'b1, 1'b1, ta, to, got);
        n_total++;
        if (!got) $display("FAIL basic_valid: got no out_valid want out_valid");
        else n_pass++;
        n_total++;
        if (c_enc_start - ta !== 1) $display("FAIL basic_start_t: got %0d want 1", c_enc_start - ta);
        else n_pass++;
        n_total++;
        if (q_addr.size() !== 3 || q_addr[0] !== 0 || q_addr[1] !== 1 || q_addr[2] !== 2 ||
            c_first_rd - ta !== 2)
            $display("FAIL basic_addr: got n=%0d first_t=%0d want n=3 addr 0..2 first_t=2",
                     q_addr.size(), c_first_rd - ta);
        else n_pass++;
        n_total++;
        if (q_last.size() !== 1 || c_last - ta !== 5 || q_char.size() !== 3 ||
            q_char[2] !== 32'h63)
            $display("FAIL basic_last: got nlast=%0d t=%0d want 1 at t=5 with 'c'",
                     q_last.size(), c_last - ta);
        else n_pass++;
        n_total++;
        if (w_res !== er) $display("FAIL basic_result: got %b want %b", w_res, er);
        else n_pass++;
        handshake(er, th);
    endtask

    task automatic test_empty();
        int ta, to, th, l;
        bit got;
        logic [2:0] er;
        ref_msg(0, 1'b1, 1'b1, 1'b0, l, er);
        run_msg(0, 1'b1, 1'b1, ta, to, got);
        n_total++;
        if (!got || to - ta !== 1) $display("FAIL empty_latency: got %0d want 1", to - ta);
        else n_pass++;
        n_total++;
        if (n_enc_start !== 0 || n_cls_start !== 0)
            $display("FAIL empty_no_activity: got enc=%0d cls=%0d want 0/0",
                     n_enc_start, n_cls_start);
        else n_pass++;
        n_total++;
        if (w_res !== er) $display("FAIL empty_result: got %b want %b", w_res, er);
        else n_pass++;
        handshake(er, th);
    endtask

    task automatic test_trunc();
        int ta, to, th, l, bad;
        bit got;
        logic [2:0] er;
        ref_msg(200, 1'b0, 1'b0, 1'b0, l, er);
        run_msg(200, 1'b0, 1'b0, ta, to, got);
        bad = 0;
        for (int i = 0; i < q_addr.size(); i++) if (q_addr[i] !== i) bad++;
        for (int i = 0; i < q_char.size(); i++) if (q_char[i] !== mem[i]) bad++;
        n_total++;
        if (q_addr.size() !== l || q_char.size() !== l || bad !== 0)
            $display("FAIL trunc_reads: got n=%0d bad=%0d want n=%0d bad=0",
                     q_addr.size(), bad, l);
        else n_pass++;
        n_total++;
        if (q_last.size() !== 1 || q_last[0] !== l - 1)
            $display("FAIL trunc_last: got n=%0d want one at %0d", q_last.size(), l - 1);
        else n_pass++;
        n_total++;
        if (!got || w_res !== er) $display("FAIL trunc_result: got %b want %b", w_res, er);
        else n_pass++;
        handshake(er, th);
    endtask

    task automatic test_timeout();
        int ta, to, th, l;
        bit got;
        logic [2:0] er;
        bit lab;
        lab = 1'($urandom);
        enc_hang = 1'b1;
        ref_msg(5, lab, 1'b1, 1'b1, l, er);
        run_msg(5, lab, 1'b1, ta, to, got);
        n_total++;
        if (!got || to - c_last !== TIMEOUT + 1)
            $display("FAIL enc_timeout_t: got %0d want %0d", to - c_last, TIMEOUT + 1);
        else n_pass++;
        n_total++;
        if (n_cls_start !== 0) $display("FAIL enc_timeout_cls: got %0d want 0", n_cls_start);
        else n_pass++;
        n_total++;
        if (w_res !== er) $display("FAIL enc_timeout_result: got %b want %b", w_res, er);
        else n_pass++;
        handshake(er, th);
        enc_hang = 1'b0;
        cls_hang = 1'b1;
        ref_msg(4, ~lab, 1'b1, 1'b1, l, er);
        run_msg(4, ~lab, 1'b1, ta, to, got);
        n_total++;
        if (!got || to - c_cls_start !== TIMEOUT + 1)
            $display("FAIL cls_timeout_t: got %0d want %0d", to - c_cls_start, TIMEOUT + 1);
        else n_pass++;
        n_total++;
        if (w_res !== er) $display("FAIL cls_timeout_result: got %b want %b", w_res, er);
        else n_pass++;
        handshake(er, th);
        cls_hang = 1'b0;
    endtask

    task automatic test_reset_abort();
        int ta, to, th, l, w;
        bit got;
        logic [2:0] er;
        w = 0;
        while (o_msg_ready !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        clear_obs();
        msg_length = 16'd20;
        msg_label  = 1'b1;
        msg_valid  = 1'b1;
        @(negedge clk);
        msg_valid = 1'b0;
        w = 0;
        while (!(o_char_rd_en === 1'b1 && o_char_addr === 8'd5) && w < 50) begin
            @(negedge clk);
            w++;
        end
        n_total++;
        if (o_char_addr !== 8'd5) $display("FAIL abort_reach: got addr %0d want 5", o_char_addr);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++;
        if (w_outs !== 49'd0 || o_msg_ready !== 1'b1)
            $display("FAIL abort_outs: got %h/%b want 0/1", w_outs, o_msg_ready);
        else n_pass++;
`ifdef HDC_STATS_EN
        n_total++;
        if (stat_total !== 16'd0 || stat_correct !== 16'd0)
            $display("FAIL abort_stats: got %0d/%0d want 0/0", stat_total, stat_correct);
        else n_pass++;
`endif
        @(negedge clk);
        rst_n = 1'b1;
        exp_total = 0;
        exp_correct = 0;
        @(negedge clk);
        ref_msg(2, 1'b0, 1'b1, 1'b0, l, er);
        run_msg(2, 1'b0, 1'b1, ta, to, got);
        n_total++;
        if (q_addr.size() !== 2 || q_last.size() !== 1 || q_last[0] !== 1 || n_enc_start !== 1)
            $display("FAIL abort_next_stream: got reads=%0d lasts=%0d starts=%0d want 2/1/1",
                     q_addr.size(), q_last.size(), n_enc_start);
        else n_pass++;
        n_total++;
        if (!got || w_res !== er) $display("FAIL abort_next_result: got %b want %b", w_res, er);
        else n_pass++;
        handshake(er, th);
    endtask

    task automatic test_backpressure();
        int ta, to, th, l, bad;
        bit got;
        logic [2:0] er;
        ref_msg(4, 1'b0, 1'b0, 1'b0, l, er);
        run_msg(4, 1'b0, 1'b0, ta, to, got);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            out_ready  = 1'b0;
            msg_valid  = 1'b1;
            msg_length = 16'd3;
            @(negedge clk);
            if (o_out_valid !== 1'b1 || w_res !== er || o_msg_ready !== 1'b0) bad++;
        end
        msg_valid = 1'b0;
        n_total++;
        if (!got || bad !== 0) $display("FAIL backpressure_hold: got %0d bad cycles want 0", bad);
        else n_pass++;
        n_total++;
        if (n_enc_start !== 1) $display("FAIL backpressure_ignore: got %0d starts want 1",
                                        n_enc_start);
        else n_pass++;
        handshake(er, th);
        n_total++;
        if (o_out_valid !== 1'b0 || o_msg_ready !== 1'b1)
            $display("FAIL handshake_release: got valid=%b ready=%b want 0/1",
                     o_out_valid, o_msg_ready);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int ta, to, th, ta2, l;
        bit got;
        logic [2:0] er;
        ref_msg(1, 1'b1, 1'b0, 1'b0, l, er);
        run_msg(1, 1'b1, 1'b0, ta, to, got);
        handshake(er, th);
        ref_msg(2, 1'b1, 1'b1, 1'b0, l, er);
        run_msg(2, 1'b1, 1'b1, ta2, to, got);
        n_total++;
        if (ta2 - th !== 1) $display("FAIL b2b_bubble: got %0d want 1", ta2 - th);
        else n_pass++;
        n_total++;
        if (!got || w_res !== er) $display("FAIL b2b_result: got %b want %b", w_res, er);
        else n_pass++;
        handshake(er, th);
    endtask

    task automatic test_random();
        int ta, to, th, l, len, r, bad;
        bit got, lab, cres;
        logic [2:0] er;
        for (int m = 0; m < 10; m++) begin
            r = $urandom_range(0, 9);
            len = (r == 0) ? MAX_LEN : (r == 1) ? $urandom_range(161, 220)
                                                : $urandom_range(1, 12);
            lab = 1'($urandom);
            cres = 1'($urandom);
            enc_delay = $urandom_range(0, 6);
            cls_delay = $urandom_range(0, 6);
            enc_noise = 1'($urandom);
            ref_msg(len, lab, cres, 1'b0, l, er);
            run_msg(len, lab, cres, ta, to, got);
            bad = 0;
            for (int i = 0; i < q_addr.size(); i++) if (q_addr[i] !== i) bad++;
            for (int i = 0; i < q_char.size(); i++) if (q_char[i] !== mem[i]) bad++;
            n_total++;
            if (!got) $display("FAIL rand_valid: msg %0d got no result want result", m);
            else n_pass++;
            n_total++;
            if (q_addr.size() !== l || q_char.size() !== l)
                $display("FAIL rand_count: msg %0d got %0d/%0d want %0d",
                         m, q_addr.size(), q_char.size(), l);
            else n_pass++;
            n_total++;
            if (bad !== 0) $display("FAIL rand_stream: msg %0d got %0d bad want 0", m, bad);
            else n_pass++;
            n_total++;
            if (q_last.size() !== 1 || q_last[0] !== l - 1)
                $display("FAIL rand_last: msg %0d got n=%0d want one at %0d",
                         m, q_last.size(), l - 1);
            else n_pass++;
            n_total++;
            if (n_enc_start !== 1 || n_cls_start !== 1 || c_enc_start - ta !== 1 ||
                c_first_rd - ta !== 2)
                $display("FAIL rand_pulses: msg %0d got enc=%0d cls=%0d t=%0d/%0d want 1/1/1/2",
                         m, n_enc_start, n_cls_start, c_enc_start - ta, c_first_rd - ta);
            else n_pass++;
            n_total++;
            if (w_res !== er) $display("FAIL rand_result: msg %0d got %b want %b", m, w_res, er);
            else n_pass++;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            handshake(er, th);
        end
        enc_noise = 1'b0;
    endtask

`ifdef HDC_STATS_EN
    task automatic test_stats();
        n_total++;
        if (stat_total !== 16'(exp_total) || stat_correct !== 16'(exp_correct))
            $display("FAIL stats: got %0d/%0d want %0d/%0d",
                     stat_total, stat_correct, exp_total, exp_correct);
        else n_pass++;
    endtask
`endif

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        rst_n      = 1'b0;
        msg_valid  = 1'b0;
        msg_length = '0;
        msg_label  = 1'b0;
        out_ready  = 1'b0;
        clear_obs();
        test_reset();
        test_basic();
        test_empty();
        test_trunc();
        test_timeout();
        test_reset_abort();
        test_backpressure();
        test_back_to_back();
        test_random();
`ifdef HDC_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
